programmable_counter: RTL



---
 rtl/programmable_counter.sv | 108 ++++++++++
 1 files changed

// File: rtl/programmable_counter.sv
// Programmable up/down counter with runtime modulus, one-shot/continuous modes,
// synchronous load/clear and a saturating wrap-event counter.
module programmable_counter #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned WRAP_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enb,
   input  logic              sync_rst_enb,
   input  logic              start,
   input  logic              mode_oneshot,
   input  logic              dir_down,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_value,
   input  logic [WIDTH-1:0]  max_value,
   output logic [WIDTH-1:0]  count,
   output logic              flag,
   output logic              tc_pulse,
   output logic              busy,
   output logic              done,
   output logic [WRAP_W-1:0] wrap_count
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   localparam logic [WRAP_W-1:0] WrapMax = '1;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  count_q, count_d;
   logic [WRAP_W-1:0] wrap_q, wrap_d;
   logic              busy_q, done_q;
   logic              step, term;

   // Step qualification and terminal detection for the current direction.
   always_comb begin
      step = (state_q == StRun) & enb & ~load & ~sync_rst_enb;
      // Up mode treats any count above the modulus as terminal.
      term = dir_down ? (count_q == '0) : (count_q >= max_value);
   end

   assign count      = count_q;
   assign flag       = dir_down ? (count_q == '0) : (count_q == max_value);
   assign tc_pulse   = step & term;
   assign busy       = busy_q;
   assign done       = done_q;
   assign wrap_count = wrap_q;

   // Next-state: clear, then load, then start, then counting step.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      wrap_d  = wrap_q;
      if (sync_rst_enb) begin
         state_d = StIdle;
         count_d = '0;
         wrap_d  = '0;
      end else if (load) begin
         count_d = load_value;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) state_d = StRun;
            end
            StRun: begin
               if (enb) begin
                  if (term) begin
                     if (wrap_q != WrapMax) wrap_d = wrap_q + 1'b1;
                     if (mode_oneshot) begin
                        // One-shot parks on the terminal value instead of wrapping.
                        count_d = dir_down ? '0 : max_value;
                        state_d = StDone;
                     end else begin
                        count_d = dir_down ? max_value : '0;
                     end
                  end else begin
                     count_d = dir_down ? count_q - 1'b1 : count_q + 1'b1;
                  end
               end
            end
            StDone: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // State, count and status registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         count_q <= '0;
         wrap_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         wrap_q  <= wrap_d;
         busy_q  <= (state_d == StRun);
         done_q  <= (state_d == StDone);
      end
   end

endmodule
